branch_resolve: RTL and testbench

Execute-stage control-flow resolution unit for the RV32I pipeline. It sits directly downstream of the branch comparator `cmp`. It consumes that block's `br_en` together with the EX-stage PC, immediate and rs1, and decides the actual next PC for each branch or jump. On a misprediction it drives a held redirect handshake to fetch and a one-cycle flush. It also owns the 2-bit branch history table that fetch queries for predictions.

---
 rtl/rv32i_types.sv | 38 +++
 rtl/branch_bht.sv | 32 +++
 rtl/branch_resolve.sv | 156 +++++++++++++++
 tb/tb_branch_resolve.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: control-flow kinds, BHT counters, resolve FSM.
package rv32i_types;

  typedef enum logic [1:0] {
    CK_NONE   = 2'd0,
    CK_BRANCH = 2'd1,
    CK_JAL    = 2'd2,
    CK_JALR   = 2'd3
  } ctrl_kind_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t WT  = 2'b10;
  localparam bht_ctr_t ST  = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } br_state_t;

  // Saturating 2-bit counter step.
  function automatic bht_ctr_t bht_next(
    input bht_ctr_t c,
    input logic     t
  );
    bht_ctr_t n;
    n = c;
    unique case (1'b1)
      t && (c != ST):   n = c + 2'd1;
      !t && (c != SNT): n = c - 2'd1;
      default:          n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit counters, one comb read port, one write port.
module branch_bht
  import rv32i_types::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int IW = $clog2(BHT_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_taken,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  bht_ctr_t ctr_q [BHT_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= bht_next(ctr_q[wr_idx], wr_taken);
    end
  end

  // Read sees the pre-update value on a same-index write.
  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution, redirect handshake and BHT owner.
// Optional perf counters are built when BRANCH_PERF_EN is defined.
module branch_resolve
  import rv32i_types::*;
#(
  parameter int width       = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  ctrl_kind_t       ex_kind,
  input  logic [width-1:0] ex_pc,
  input  logic [width-1:0] ex_imm,
  input  logic [width-1:0] ex_rs1,
  input  logic             br_en,
  input  logic             ex_pred_taken,
  input  logic [width-1:0] ex_pred_target,
  output logic             ex_stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [width-1:0] redirect_pc,
  input  logic             redirect_ready,
  input  logic [width-1:0] if_pc,
  output logic             if_pred_taken,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  localparam int IW = $clog2(BHT_ENTRIES);

  br_state_t        state_q;
  br_state_t        state_d;
  logic             first_q;
  logic [width-1:0] redirect_pc_q;

  logic             resolve;
  logic             taken;
  logic [width-1:0] target;
  logic [width-1:0] fall_pc;
  logic [width-1:0] corr_pc;
  logic             mispredict;
  logic             bht_wr;
  logic             unused_ok;

  assign resolve = ex_valid
                && (ex_kind != CK_NONE)
                && (state_q == IDLE);

  always_comb begin
    taken  = 1'b0;
    target = ex_pc + ex_imm;
    unique case (1'b1)
      ex_kind == CK_BRANCH: taken = br_en;
      ex_kind == CK_JAL:    taken = 1'b1;
      ex_kind == CK_JALR: begin
        taken  = 1'b1;
        target = (ex_rs1 + ex_imm)
               & {{(width-1){1'b1}}, 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  assign fall_pc = ex_pc + width'(4);
  assign corr_pc = taken ? target : fall_pc;

  assign mispredict = (ex_pred_taken != taken)
                   || (taken && (ex_pred_target != target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      first_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == IDLE)
              && (state_d == REDIRECT);
      if (resolve && mispredict) begin
        redirect_pc_q <= corr_pc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (resolve && mispredict) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state.
  always_comb begin
    ex_stall       = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    if (state_q == REDIRECT) begin
      ex_stall       = 1'b1;
      redirect_valid = 1'b1;
      flush          = first_q;
    end
  end

  assign redirect_pc = redirect_pc_q;

  assign bht_wr = resolve && (ex_kind == CK_BRANCH);

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[2 +: IW]),
    .rd_taken (if_pred_taken),
    .wr_en    (bht_wr),
    .wr_idx   (ex_pc[2 +: IW]),
    .wr_taken (br_en)
  );

`ifdef BRANCH_PERF_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (resolve) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

  assign unused_ok = ^if_pc;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: redirects, BHT training, reset.
module tb_branch_resolve;
  import rv32i_types::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  ctrl_kind_t  ex_kind;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        br_en;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks;
  int errors;

  branch_resolve #(
    .width       (32),
    .BHT_ENTRIES (64)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_kind          (ex_kind),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_rs1           (ex_rs1),
    .br_en            (br_en),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_stall         (ex_stall),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ctrl_kind_t k,
                       input logic [31:0] pc,
                       input logic [31:0] imm,
                       input logic [31:0] rs1,
                       input logic        be,
                       input logic        pt,
                       input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_kind        = k;
    ex_pc          = pc;
    ex_imm         = imm;
    ex_rs1         = rs1;
    br_en          = be;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_kind  = CK_NONE;
  endtask

  task automatic do_reset();
    idle();
    redirect_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    br_en = 1'b0; ex_pred_taken = 1'b0;
    ex_pred_target = '0;
    redirect_ready = 1'b0;
    if_pc = 32'h100;
    do_reset();

    // Reset state
    chk("rst_stall", {31'd0, ex_stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_bht", {31'd0, if_pred_taken}, 32'd0);
    chk("rst_bcnt", branch_count, 32'd0);
    chk("rst_mcnt", mispredict_count, 32'd0);

    // BEQ 0x100 +0x20 taken, predicted not-taken
    issue(CK_BRANCH, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
    #2;
    chk("beq_n_stall", {31'd0, ex_stall}, 32'd0);
    chk("beq_n_bht_old", {31'd0, if_pred_taken}, 32'd0);
    tick();
    idle();
    redirect_ready = 1'b1;
    #2;
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq_rpc", redirect_pc, 32'h120);
    chk("beq_stall", {31'd0, ex_stall}, 32'd1);
    chk("beq_bht_wt", {31'd0, if_pred_taken}, 32'd1);
    tick();
    redirect_ready = 1'b0;
    #2;
    chk("beq_n2_rv", {31'd0, redirect_valid}, 32'd0);
    chk("beq_n2_stall", {31'd0, ex_stall}, 32'd0);
    chk("beq_n2_flush", {31'd0, flush}, 32'd0);
`ifdef BRANCH_PERF_EN
    chk("beq_bcnt", branch_count, 32'd1);
    chk("beq_mcnt", mispredict_count, 32'd1);
`else
    chk("beq_bcnt0", branch_count, 32'd0);
`endif

    // BNE 0x200 not taken, predicted not-taken: WNT -> SNT
    do_reset();
    if_pc = 32'h200;
    issue(CK_BRANCH, 32'h200, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    #2;
    chk("bne_flush", {31'd0, flush}, 32'd0);
    chk("bne_rv", {31'd0, redirect_valid}, 32'd0);
    chk("bne_bht", {31'd0, if_pred_taken}, 32'd0);
    tick();
    // Taken once more: SNT -> WNT must still predict not-taken
    issue(CK_BRANCH, 32'h200, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
    redirect_ready = 1'b1;
    #2;
    chk("bne_tk_rpc", redirect_pc, 32'h240);
    chk("bne_snt_wnt", {31'd0, if_pred_taken}, 32'd0);
    tick();
    redirect_ready = 1'b0;

    // JALR: rs1 0x1003 + 4, &~1 = 0x1006
    do_reset();
    issue(CK_JALR, 32'h500, 32'h4, 32'h1003, 1'b0, 1'b1, 32'h1006);
    tick();
    idle();
    #2;
    chk("jalr_ok_rv", {31'd0, redirect_valid}, 32'd0);
    chk("jalr_ok_flush", {31'd0, flush}, 32'd0);
    issue(CK_JALR, 32'h500, 32'h4, 32'h1003, 1'b0, 1'b1, 32'h1000);
    tick();
    // Held redirect, ready low 3 cycles; new branch ignored
    if_pc = 32'h300;
    issue(CK_BRANCH, 32'h300, 32'h80, 32'h0, 1'b1, 1'b0, 32'h0);
    #2;
    chk("jalr_rpc", redirect_pc, 32'h1006);
    chk("hold1_flush", {31'd0, flush}, 32'd1);
    chk("hold1_rv", {31'd0, redirect_valid}, 32'd1);
    for (int i = 2; i <= 3; i++) begin
      tick();
      #2;
      chk("hold_flush", {31'd0, flush}, 32'd0);
      chk("hold_rv", {31'd0, redirect_valid}, 32'd1);
      chk("hold_stall", {31'd0, ex_stall}, 32'd1);
      chk("hold_rpc", redirect_pc, 32'h1006);
    end
    tick();
    idle();
    redirect_ready = 1'b1;
    #2;
    chk("hold4_rv", {31'd0, redirect_valid}, 32'd1);
    chk("hold4_flush", {31'd0, flush}, 32'd0);
    tick();
    redirect_ready = 1'b0;
    #2;
    chk("rel_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rel_stall", {31'd0, ex_stall}, 32'd0);
    chk("ign_bht", {31'd0, if_pred_taken}, 32'd0);
`ifdef BRANCH_PERF_EN
    chk("jalr_bcnt", branch_count, 32'd2);
    chk("jalr_mcnt", mispredict_count, 32'd1);
`endif

    // JAL predicted correctly: no redirect, no BHT update
    issue(CK_JAL, 32'h300, 32'h10, 32'h0, 1'b0, 1'b1, 32'h310);
    tick();
    idle();
    #2;
    chk("jal_rv", {31'd0, redirect_valid}, 32'd0);
    chk("jal_bht", {31'd0, if_pred_taken}, 32'd0);

    // Four taken at 0x0 saturate to ST
    do_reset();
    if_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      issue(CK_BRANCH, 32'h0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h40);
      tick();
      idle();
      #2;
      chk("sat_bht", {31'd0, if_pred_taken}, 32'd1);
      chk("sat_rv", {31'd0, redirect_valid}, 32'd0);
    end
    issue(CK_BRANCH, 32'h0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h40);
    tick();
    idle();
    redirect_ready = 1'b1;
    #2;
    chk("st_wt_bht", {31'd0, if_pred_taken}, 32'd1);
    chk("st_wt_rpc", redirect_pc, 32'h4);
    tick();
    redirect_ready = 1'b0;
    issue(CK_BRANCH, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    #2;
    chk("wt_wnt_bht", {31'd0, if_pred_taken}, 32'd0);

    // Fall-through wraps at 0xFFFFFFFC
    issue(CK_BRANCH, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b1, 32'h4);
    tick();
    idle();
    redirect_ready = 1'b1;
    #2;
    chk("wrap_rv", {31'd0, redirect_valid}, 32'd1);
    chk("wrap_rpc", redirect_pc, 32'h0);
    tick();
    redirect_ready = 1'b0;

    // Reset in the middle of REDIRECT
    do_reset();
    if_pc = 32'h100;
    issue(CK_BRANCH, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
    #2;
    chk("mid_flush", {31'd0, flush}, 32'd1);
    chk("mid_bht_pre", {31'd0, if_pred_taken}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_stall", {31'd0, ex_stall}, 32'd0);
    chk("mr_flush", {31'd0, flush}, 32'd0);
    chk("mr_rv", {31'd0, redirect_valid}, 32'd0);
    chk("mr_rpc", redirect_pc, 32'd0);
    chk("mr_bht", {31'd0, if_pred_taken}, 32'd0);
    chk("mr_bcnt", branch_count, 32'd0);
    chk("mr_mcnt", mispredict_count, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    #2;
    chk("post_flush", {31'd0, flush}, 32'd0);
    chk("post_rv", {31'd0, redirect_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
